// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if: control inputs and select/status outputs of the mux select sequencer
interface mux_sel_sequencer_if;
  logic       en;
  logic       mode;
  logic       step;
  logic [7:0] mask;
  logic       SEL0;
  logic       SEL1;
  logic       SEL2;
  logic       sel_change;
  logic       frame_done;
  logic       active;
  modport master (output en, mode, step, mask, input SEL0, SEL1, SEL2, sel_change, frame_done, active);
  modport slave  (input en, mode, step, mask, output SEL0, SEL1, SEL2, sel_change, frame_done, active);
endinterface

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: steps SEL lines over enabled channels, auto-dwell or manual step
module mux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  mux_sel_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [2:0] idx, idx_n, first, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic chg, chg_n, fd, fd_n, adv;
  // later iterations overwrite, so the lowest bit / nearest successor wins
  always_comb begin
    first = '0;
    nxt = idx;
    for (int k = 7; k >= 0; k--) if (bus.mask[k]) first = 3'(k);
    for (int k = 8; k >= 1; k--) if (bus.mask[idx + 3'(k)]) nxt = idx + 3'(k);
  end
  // manual mode keeps the counter at 0, so any mode change also clears it
  assign adv = ~bus.mask[idx] | (bus.mode ? bus.step : cnt == CNT_W'(DWELL - 1));
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = '0;
    chg_n = 1'b0;
    fd_n = 1'b0;
    if (state == IDLE) begin
      if (bus.en && |bus.mask) begin
        state_n = RUN;
        idx_n = first;
        chg_n = 1'b1;
      end
    end else if (!bus.en || bus.mask == '0) begin
      state_n = IDLE;
    end else if (adv) begin
      idx_n = nxt;
      chg_n = 1'b1;
      fd_n = nxt <= idx;
    end else begin
      cnt_n = bus.mode ? '0 : cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      chg <= 1'b0;
      fd <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      chg <= chg_n;
      fd <= fd_n;
    end
  end
  assign {bus.SEL0, bus.SEL1, bus.SEL2} = idx;
  assign bus.sel_change = chg;
  assign bus.frame_done = fd;
  assign bus.active = state == RUN;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: table-driven vectors plus hand sequences for scans and single channel
module tb_mux_sel_sequencer;
  logic clk = 1'b0;
  logic rst;
  int pass_cnt = 0;
  int total = 0;
  mux_sel_sequencer_if bus();
  mux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic       r, en, mode, step;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       chg, fd, act;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic en, logic mode, logic step, logic [7:0] mask,
                              logic [2:0] sel, logic chg, logic fd, logic act);
    vec_t v;
    v.r = r; v.en = en; v.mode = mode; v.step = step; v.mask = mask;
    v.sel = sel; v.chg = chg; v.fd = fd; v.act = act;
    return v;
  endfunction

  task automatic drive(logic r, logic en, logic mode, logic step, logic [7:0] mask);
    rst = r; bus.en = en; bus.mode = mode; bus.step = step; bus.mask = mask;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [2:0] sel, logic chg, logic fd, logic act);
    logic [5:0] got, exp;
    got = {bus.SEL0, bus.SEL1, bus.SEL2, bus.sel_change, bus.frame_done, bus.active};
    exp = {sel, chg, fd, act};
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got sel=%b chg=%b fd=%b act=%b, want sel=%b chg=%b fd=%b act=%b",
                  name, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
  endtask

  initial begin
    int seq[3];
    int fd_seen;
    logic [2:0] e;
    seq = '{2, 5, 7};
    // reset, manual stepping, mode switch, mid-dwell disable, stop at dwell end
    tbl.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 4, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 5, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 6, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 7, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 2, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 8'hFF, 4, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'hFF, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 8'hFF, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 4, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 5, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 5, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hDF, 6, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 6, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 6, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'hFF, 6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'hFF, 6, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'hA4, 2, 1, 0, 1));
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].mode, tbl[i].step, tbl[i].mask);
      chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].chg, tbl[i].fd, tbl[i].act);
    end
    // masked scan continues: 2,5,7,2,... each held 4 cycles
    for (int c = 1; c < 24; c++) begin
      drive(0, 1, 0, 0, 8'hA4);
      chk($sformatf("mscan%0d", c), 3'(seq[(c / 4) % 3]), c % 4 == 0,
          (c % 4 == 0) && (c / 4) % 3 == 0, 1);
    end
    // only A enabled: current H disabled, jump to A, then pulses every dwell
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, 0, 0, 8'h01);
      chk($sformatf("single%0d", c), 0, c % 4 == 0, c % 4 == 0, 1);
    end
    drive(0, 1, 0, 0, 8'h00);
    chk("mask0_idle", 0, 0, 0, 0);
    drive(0, 1, 0, 0, 8'hFF);
    chk("fscan_start", 0, 1, 0, 1);
    fd_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      drive(0, 1, 0, 0, 8'hFF);
      e = 3'((c / 4) % 8);
      fd_seen += int'(bus.frame_done);
      chk($sformatf("fscan%0d", c), e, c % 4 == 0, (c % 4 == 0) && e == 0, 1);
    end
    total++;
    if (fd_seen == 1) pass_cnt++;
    else $display("FAIL fscan_fd_count: got %0d want 1", fd_seen);
    drive(1, 1, 0, 0, 8'hFF);
    chk("rst_mid_run", 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
